// File: rtl/mips_pkg.sv
// Shared MIPS core types: address type, program-counter sequencer states,
// and the reset/halt address constants.
package mips_pkg;

    typedef logic [31:0] address_t;

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_DELAY = 2'd1,
        ST_HALT  = 2'd2
    } pc_state_e;

    localparam address_t RESET_VECTOR_DEF = 32'hBFC0_0000;
    localparam address_t HALT_ADDR_DEF    = 32'h0000_0000;

endpackage

// File: rtl/branch_target_calc.sv
// Combinational MIPS branch target: (pc+4) + (sext(imm) << 2), modulo 2^32.
// Also exports pc+4 so the caller does not need a second adder.
module branch_target_calc
    import mips_pkg::*;
(
    input  logic [31:0] pc_i,
    input  logic [15:0] imm_i,
    output logic [31:0] pc_plus4_o,
    output logic [31:0] target_o
);

    logic [31:0] offset;

    always_comb begin
        offset     = {{14{imm_i[15]}}, imm_i, 2'b00};
        pc_plus4_o = pc_i + 32'd4;
        target_o   = pc_plus4_o + offset;
    end

endmodule

// File: rtl/pc_sequencer.sv
// Program-counter owner for the MIPS core: delay-slot redirects for
// J/JAL, JR/JALR and taken branches, fetch stalls, and halt-on-jump-to-zero.
module pc_sequencer
    import mips_pkg::*;
#(
    parameter address_t RESET_VECTOR = RESET_VECTOR_DEF,
    parameter address_t HALT_ADDR    = HALT_ADDR_DEF
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        stall,
    input  logic        jump_en,
    input  logic [31:0] jump_target,
    input  logic        branch_en,
    input  logic [15:0] branch_offset,
    input  logic        jr_en,
    input  logic [31:0] jr_target,
    output logic [31:0] pc,
    output logic [3:0]  pc_4msb,
    output logic        delay_slot,
    output logic        halted,
    output logic        addr_err
);

    pc_state_e   state_q, state_d;
    address_t    pc_q, pc_d;
    address_t    target_q, target_d;
    logic        halted_q, halted_d;
    logic        addr_err_q, addr_err_d;
    logic [31:0] pc_plus4;
    logic [31:0] branch_tgt;

    branch_target_calc u_btc (
        .pc_i       (pc_q),
        .imm_i      (branch_offset),
        .pc_plus4_o (pc_plus4),
        .target_o   (branch_tgt)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= ST_RUN;
            pc_q       <= RESET_VECTOR;
            target_q   <= '0;
            halted_q   <= 1'b0;
            addr_err_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            target_q   <= target_d;
            halted_q   <= halted_d;
            addr_err_q <= addr_err_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        target_d   = target_q;
        halted_d   = halted_q;
        addr_err_d = addr_err_q;
        if (!stall) begin
            unique case (state_q)
                ST_RUN: begin
                    // jr outranks jump, which outranks branch
                    if (jr_en) begin
                        if (jr_target[1:0] != 2'b00) begin
                            addr_err_d = 1'b1;
                            state_d    = ST_HALT;
                        end else begin
                            target_d = jr_target;
                            pc_d     = pc_plus4;
                            state_d  = ST_DELAY;
                        end
                    end else if (jump_en) begin
                        target_d = jump_target;
                        pc_d     = pc_plus4;
                        state_d  = ST_DELAY;
                    end else if (branch_en) begin
                        target_d = branch_tgt;
                        pc_d     = pc_plus4;
                        state_d  = ST_DELAY;
                    end else begin
                        pc_d = pc_plus4;
                    end
                end
                ST_DELAY: begin
                    pc_d = target_q;
                    if (target_q == HALT_ADDR) begin
                        halted_d = 1'b1;
                        state_d  = ST_HALT;
                    end else begin
                        state_d = ST_RUN;
                    end
                end
                ST_HALT: ;
                default: state_d = ST_HALT;
            endcase
        end
    end

    assign pc         = pc_q;
    assign pc_4msb    = pc_plus4[31:28];
    assign delay_slot = (state_q == ST_DELAY);
    assign halted     = halted_q;
    assign addr_err   = addr_err_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed-vector bench for pc_sequencer: reset, jump/branch/jr redirects,
// priority, wrap, halt, stalls and misaligned-jr error.
module tb_pc_sequencer;

    logic        clk = 1'b0;
    logic        reset;
    logic        stall;
    logic        jump_en;
    logic [31:0] jump_target;
    logic        branch_en;
    logic [15:0] branch_offset;
    logic        jr_en;
    logic [31:0] jr_target;
    logic [31:0] pc;
    logic [3:0]  pc_4msb;
    logic        delay_slot;
    logic        halted;
    logic        addr_err;

    int vecs = 0;
    int errs = 0;

    pc_sequencer dut (
        .clk           (clk),
        .reset         (reset),
        .stall         (stall),
        .jump_en       (jump_en),
        .jump_target   (jump_target),
        .branch_en     (branch_en),
        .branch_offset (branch_offset),
        .jr_en         (jr_en),
        .jr_target     (jr_target),
        .pc            (pc),
        .pc_4msb       (pc_4msb),
        .delay_slot    (delay_slot),
        .halted        (halted),
        .addr_err      (addr_err)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        stall = 0; jump_en = 0; jump_target = '0; branch_en = 0;
        branch_offset = '0; jr_en = 0; jr_target = '0;
    endtask

    task automatic do_reset();
        clear_inputs();
        reset = 1;
        step();
        reset = 0;
    endtask

    // From reset, jump so that pc lands on addr two cycles later.
    task automatic go_to(input logic [31:0] addr);
        do_reset();
        jump_en = 1; jump_target = addr;
        step();
        jump_en = 0;
        step();
    endtask

    task automatic test_reset();
        logic [31:0] exp_pc;
        do_reset();
        vecs++; if (pc !== 32'hBFC00000) begin errs++; $display("FAIL reset_pc got %h want %h", pc, 32'hBFC00000); end
        vecs++; if ({halted, delay_slot, addr_err} !== 3'b000) begin errs++; $display("FAIL reset_flags got %b want 000", {halted, delay_slot, addr_err}); end
        exp_pc = 32'hBFC00000;
        for (int i = 0; i < 3; i++) begin
            step();
            exp_pc = exp_pc + 32'd4;
            vecs++; if (pc !== exp_pc) begin errs++; $display("FAIL seq_pc%0d got %h want %h", i, pc, exp_pc); end
            vecs++; if ({halted, delay_slot} !== 2'b00) begin errs++; $display("FAIL seq_flags%0d got %b want 00", i, {halted, delay_slot}); end
        end
    endtask

    task automatic test_jump();
        step();
        vecs++; if (pc !== 32'hBFC00010) begin errs++; $display("FAIL jump_start got %h want BFC00010", pc); end
        vecs++; if (pc_4msb !== 4'hB) begin errs++; $display("FAIL jump_4msb got %h want B", pc_4msb); end
        jump_en = 1; jump_target = 32'h1C11C004;
        step();
        jump_en = 0; jump_target = '0;
        vecs++; if (pc !== 32'hBFC00014 || delay_slot !== 1'b1) begin errs++; $display("FAIL jump_ds got %h/%b want BFC00014/1", pc, delay_slot); end
        step();
        vecs++; if (pc !== 32'h1C11C004 || delay_slot !== 1'b0) begin errs++; $display("FAIL jump_tgt got %h/%b want 1C11C004/0", pc, delay_slot); end
        vecs++; if (pc_4msb !== 4'h1) begin errs++; $display("FAIL jump_tgt_4msb got %h want 1", pc_4msb); end
    endtask

    task automatic test_branch();
        go_to(32'h00400020);
        branch_en = 1; branch_offset = 16'hFFFE;
        step();
        branch_en = 0;
        vecs++; if (pc !== 32'h00400024 || delay_slot !== 1'b1) begin errs++; $display("FAIL br_neg_ds got %h/%b want 00400024/1", pc, delay_slot); end
        step();
        vecs++; if (pc !== 32'h0040001C) begin errs++; $display("FAIL br_neg_tgt got %h want 0040001C", pc); end
        go_to(32'h00400020);
        branch_en = 1; branch_offset = 16'h0003;
        step();
        branch_en = 0;
        vecs++; if (pc !== 32'h00400024) begin errs++; $display("FAIL br_pos_ds got %h want 00400024", pc); end
        step();
        vecs++; if (pc !== 32'h00400030) begin errs++; $display("FAIL br_pos_tgt got %h want 00400030", pc); end
    endtask

    task automatic test_priority();
        go_to(32'h00400020);
        jr_en = 1; jr_target = 32'h00002000;
        jump_en = 1; jump_target = 32'h00003000;
        branch_en = 1; branch_offset = 16'h0010;
        step();
        clear_inputs();
        // a branch in the delay slot must be dropped
        branch_en = 1; branch_offset = 16'h0100;
        step();
        branch_en = 0;
        vecs++; if (pc !== 32'h00002000) begin errs++; $display("FAIL prio_jr got %h want 00002000", pc); end
        jump_en = 1; jump_target = 32'h00003000;
        branch_en = 1; branch_offset = 16'h0010;
        step();
        clear_inputs();
        step();
        vecs++; if (pc !== 32'h00003000) begin errs++; $display("FAIL prio_jump got %h want 00003000", pc); end
    endtask

    task automatic test_wrap();
        go_to(32'hFFFFFFF8);
        step();
        vecs++; if (pc !== 32'hFFFFFFFC || pc_4msb !== 4'h0) begin errs++; $display("FAIL wrap_top got %h/%h want FFFFFFFC/0", pc, pc_4msb); end
        step();
        vecs++; if (pc !== 32'h00000000 || halted !== 1'b0) begin errs++; $display("FAIL wrap_zero got %h/%b want 00000000/0", pc, halted); end
    endtask

    task automatic test_halt();
        do_reset();
        step(); step();
        jr_en = 1; jr_target = 32'h00000000;
        step();
        jr_en = 0;
        vecs++; if (pc !== 32'hBFC0000C || delay_slot !== 1'b1) begin errs++; $display("FAIL halt_ds got %h/%b want BFC0000C/1", pc, delay_slot); end
        step();
        vecs++; if (pc !== 32'h0 || halted !== 1'b1 || delay_slot !== 1'b0) begin errs++; $display("FAIL halt_enter got %h/%b/%b want 0/1/0", pc, halted, delay_slot); end
        jump_en = 1; jump_target = 32'h00001000; branch_en = 1; branch_offset = 16'h0004;
        for (int i = 0; i < 4; i++) begin
            stall = i[0];
            step();
        end
        clear_inputs();
        vecs++; if (pc !== 32'h0 || halted !== 1'b1) begin errs++; $display("FAIL halt_sticky got %h/%b want 0/1", pc, halted); end
    endtask

    task automatic test_stall();
        do_reset();
        step(); step();
        jump_en = 1; jump_target = 32'h00001000; stall = 1;
        for (int i = 0; i < 3; i++) begin
            step();
            vecs++; if (pc !== 32'hBFC00008 || delay_slot !== 1'b0) begin errs++; $display("FAIL stall_run%0d got %h/%b want BFC00008/0", i, pc, delay_slot); end
        end
        stall = 0;
        step();
        jump_en = 0;
        vecs++; if (pc !== 32'hBFC0000C || delay_slot !== 1'b1) begin errs++; $display("FAIL stall_ds got %h/%b want BFC0000C/1", pc, delay_slot); end
        stall = 1;
        for (int i = 0; i < 2; i++) begin
            step();
            vecs++; if (pc !== 32'hBFC0000C || delay_slot !== 1'b1) begin errs++; $display("FAIL stall_dly%0d got %h/%b want BFC0000C/1", i, pc, delay_slot); end
        end
        stall = 0;
        step();
        vecs++; if (pc !== 32'h00001000 || delay_slot !== 1'b0) begin errs++; $display("FAIL stall_tgt got %h/%b want 00001000/0", pc, delay_slot); end
    endtask

    task automatic test_addr_err();
        do_reset();
        jr_en = 1; jr_target = 32'h00400002;
        step();
        jr_en = 0;
        vecs++; if (addr_err !== 1'b1 || halted !== 1'b0) begin errs++; $display("FAIL aerr_flags got %b/%b want 1/0", addr_err, halted); end
        vecs++; if (pc !== 32'hBFC00000 || delay_slot !== 1'b0) begin errs++; $display("FAIL aerr_pc got %h/%b want BFC00000/0", pc, delay_slot); end
        jump_en = 1; jump_target = 32'h00001000;
        step(); step();
        jump_en = 0;
        vecs++; if (pc !== 32'hBFC00000 || addr_err !== 1'b1) begin errs++; $display("FAIL aerr_frozen got %h/%b want BFC00000/1", pc, addr_err); end
        // mid-DELAY jump with async reset: the latched target must be discarded
        jump_en = 1; jump_target = 32'h00005000;
        reset = 1; #1; reset = 0;
        step();
        jump_en = 0;
        vecs++; if (pc !== 32'hBFC00004 || delay_slot !== 1'b1) begin errs++; $display("FAIL rst_ds got %h/%b want BFC00004/1", pc, delay_slot); end
        #2;
        reset = 1;
        #1;
        vecs++; if (pc !== 32'hBFC00000 || addr_err !== 1'b0 || delay_slot !== 1'b0) begin errs++; $display("FAIL async_rst got %h/%b/%b want BFC00000/0/0", pc, addr_err, delay_slot); end
        step();
        reset = 0;
        step();
        vecs++; if (pc !== 32'hBFC00004 || delay_slot !== 1'b0) begin errs++; $display("FAIL rst_discard got %h/%b want BFC00004/0", pc, delay_slot); end
    endtask

    initial begin
        clear_inputs();
        reset = 1;
        #12;
        test_reset();
        test_jump();
        test_branch();
        test_priority();
        test_wrap();
        test_halt();
        test_stall();
        test_addr_err();
        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule
